uart_rx: RTL and testbench
==========================

# uart_rx

Receives an asynchronous 8N1 serial stream on `rx` and delivers each byte as a parallel word with a one-cycle valid strobe. It is the receive-side counterpart of the UART transmitter, uses the same BAUD_RATE/CLK_FREQ bit-period derivation, and sits between the board RX pin and the byte consumer (command parser / display logic). Start bits are validated at mid-bit, data and stop bits are sampled at mid-bit, and stop-bit violations are flagged.

## Interface
- BAUD_RATE, 9600: serial bit rate.
- CLK_FREQ, 100000000: clk frequency in Hz.
- BIT_PERIOD, CLK_FREQ/BAUD_RATE: clocks per bit (derived; 10416 at defaults).
- HALF_PERIOD, BIT_PERIOD/2: clocks from start-bit falling edge to the start-bit mid-point.
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- rx  input  1  asynchronous serial line; idle high.
- rx_data  output  8  last correctly framed byte; LSB received first.
- rx_valid  output  1  one-cycle pulse: rx_data has just been updated.
- rx_busy  output  1  high from start-bit detection until return to IDLE.
- frame_err  output  1  one-cycle pulse: stop bit was sampled low.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) giving rx_s. All decisions use rx_s only.
- FSM states:
  - IDLE
  - START
  - DATA
  - STOP
  - BREAK
- IDLE: on rx_s==0, go to START, clear the timer, set rx_busy.
- START: at timer==HALF_PERIOD-1, check rx_s.
  - rx_s==0: go to DATA, clear the timer and bit index.
  - rx_s==1: glitch. Return to IDLE with no pulses.
- DATA: at timer==BIT_PERIOD-1, shift rx_s into shift_reg[bit_index] and clear the timer.
  - After index 7, go to STOP.
- STOP: at timer==BIT_PERIOD-1, sample rx_s.
  - rx_s==1: rx_data<=shift_reg, pulse rx_valid, go to IDLE.
  - rx_s==0: pulse frame_err, leave rx_data unchanged, go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line from re-triggering start detection.
- rx_busy is high in START, DATA, STOP and BREAK.
- Timer is 16 bits unsigned. BIT_PERIOD must be ≤ 65536 and ≥ 4; widths outside this range are unsupported.
- No receive buffering. A consumer that misses the rx_valid pulse loses the byte; rx_data holds until the next good frame.

## Timing
- Reset (rst_n low at a posedge) values:
  - rx_data=8'h00
  - rx_valid=0
  - rx_busy=0
  - frame_err=0
  - FSM=IDLE
  - synchronizer=1
  - timer=0
  - bit index=0
- Reset asserted mid-frame aborts the frame with no rx_valid and no frame_err. After release, reception resumes at the next falling edge seen in IDLE.
- Edge detect latency: 2 cycles of synchronizer delay plus 1 cycle for the IDLE transition.
- Sampling instants after detection (detection counts as cycle 0):
  - start check: HALF_PERIOD
  - data bit k: HALF_PERIOD + (k+1)·BIT_PERIOD
  - stop bit: HALF_PERIOD + 9·BIT_PERIOD
- rx_valid and frame_err are registered. Each is high exactly 1 cycle, the cycle after the stop sample, and they are never both high.
- rx_data changes only on the same cycle rx_valid rises.
- Back-to-back frames: a new start bit may begin immediately after the stop bit.
  - The FSM re-enters IDLE about half a bit before the stop bit ends, so no start edge is missed.

## Structure
- Shared package `uart_pkg`: state encoding type (IDLE/START/DATA/STOP/BREAK), DATA_BITS=8, and a bit_period(clk_freq, baud) constant function, shared with the transmitter.
- One sub-module: `sync_2ff` (parameterized reset value), reused for any asynchronous input.

## Test plan
Run with CLK_FREQ=1600, BAUD_RATE=100 (BIT_PERIOD=16, HALF_PERIOD=8).
- Drive a frame for 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1): rx_valid pulses once, rx_data=0xA5, frame_err stays 0, rx_busy drops before the stop bit ends.
- Drive a 5-cycle low glitch on idle rx: no rx_valid, no frame_err, rx_busy pulses then returns to 0, rx_data unchanged.
- Drive a 0x3C frame with stop bit 0, then hold rx low for 3 bit times: one frame_err pulse, no rx_valid, rx_data keeps its previous value, rx_busy stays high until rx returns high, and no spurious second frame.
- Drive 0x00 then 0xFF back-to-back with no idle gap: two rx_valid pulses with rx_data 0x00 then 0xFF.
- Drive rst_n low for 1 cycle during data bit 4 of a frame: all outputs at reset values, no pulses for that frame, and the following 0x5A frame is received correctly.
- Loop the transmitter output into rx and send 0x01, 0x80, 0x7E: rx_data sequence matches with exactly one rx_valid per byte.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/transmitter state type, frame width and bit-period math
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    localparam int DATA_BITS = 8;
    function automatic int bit_period(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous input bit, reset to RESET_VAL
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            o_q    <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, valid strobe and stop-bit error flag
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_RATE = 9600,
    parameter int CLK_FREQ  = 100000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err
);
    localparam int BIT_PERIOD  = bit_period(CLK_FREQ, BAUD_RATE);
    localparam int HALF_PERIOD = BIT_PERIOD / 2;
    localparam logic [15:0] BIT_LAST  = 16'(BIT_PERIOD - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_PERIOD - 1);
    localparam logic [2:0]  IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 w_rx_s;
    state_t               r_state;
    logic [15:0]          r_timer;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .i_d  (rx),
        .o_q  (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                IDLE: if (!w_rx_s) begin
                    r_state <= START;
                    r_timer <= '0;
                    rx_busy <= 1'b1;
                end
                START: if (r_timer == HALF_LAST) begin
                    r_timer   <= '0;
                    r_bit_idx <= '0;
                    r_state   <= w_rx_s ? IDLE : DATA;
                    rx_busy   <= !w_rx_s;
                end else r_timer <= r_timer + 16'd1;
                DATA: if (r_timer == BIT_LAST) begin
                    r_timer            <= '0;
                    r_shift[r_bit_idx] <= w_rx_s;
                    r_bit_idx          <= r_bit_idx + 3'd1;
                    if (r_bit_idx == IDX_LAST) r_state <= STOP;
                end else r_timer <= r_timer + 16'd1;
                // Leaving at the stop mid-point keeps a back-to-back start edge visible in IDLE
                STOP: if (r_timer == BIT_LAST) begin
                    r_timer <= '0;
                    if (w_rx_s) begin
                        rx_data  <= r_shift;
                        rx_valid <= 1'b1;
                        rx_busy  <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        r_state   <= BREAK;
                    end
                end else r_timer <= r_timer + 16'd1;
                BREAK: if (w_rx_s) begin
                    r_state <= IDLE;
                    rx_busy <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenario tests for uart_rx at BIT_PERIOD=16
module tb_uart_rx;
    localparam int BIT = 16;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, frame_err;
    int         total = 0, bad = 0;
    int         vcnt = 0, fcnt = 0, both = 0, wide = 0, dchg = 0;
    logic [7:0] vlog[$];
    logic [7:0] prev_data = 8'h00;
    logic       prev_valid = 1'b0, prev_ferr = 1'b0, rst_q = 1'b0;

    uart_rx #(.BAUD_RATE(100), .CLK_FREQ(1600)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_busy  (rx_busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_q <= rst_n;

    always @(negedge clk) begin
        if (rx_valid) begin
            vcnt++;
            vlog.push_back(rx_data);
        end
        if (frame_err) fcnt++;
        if (rx_valid && frame_err) both++;
        if ((rx_valid && prev_valid) || (frame_err && prev_ferr)) wide++;
        if (rst_q && rx_data !== prev_data && !rx_valid) dchg++;
        prev_data  = rx_data;
        prev_valid = rx_valid;
        prev_ferr  = frame_err;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clk(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx = 1'b1;
        wait_clk(3);
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rx_valid); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", rx_busy); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_err); end
        rst_n = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_a5;
        int v0 = vcnt, f0 = fcnt;
        logic [7:0] d = 8'hA5;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
            if (i == 3) begin
                total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL a5_busy_mid got=%b want=1", rx_busy); end
            end
        end
        send_bit(1'b1);
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL a5_busy_stop_end got=%b want=0", rx_busy); end
        wait_clk(20);
        total++; if (vcnt != v0 + 1) begin bad++; $display("FAIL a5_valid_cnt got=%0d want=%0d", vcnt - v0, 1); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL a5_data got=%h want=a5", rx_data); end
        total++; if (fcnt != f0) begin bad++; $display("FAIL a5_ferr_cnt got=%0d want=0", fcnt - f0); end
    endtask

    task automatic test_glitch;
        int v0 = vcnt, f0 = fcnt;
        rx = 1'b0;
        wait_clk(5);
        rx = 1'b1;
        total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_rise got=%b want=1", rx_busy); end
        wait_clk(20);
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_fall got=%b want=0", rx_busy); end
        total++; if (vcnt != v0) begin bad++; $display("FAIL glitch_valid_cnt got=%0d want=0", vcnt - v0); end
        total++; if (fcnt != f0) begin bad++; $display("FAIL glitch_ferr_cnt got=%0d want=0", fcnt - f0); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL glitch_data got=%h want=a5", rx_data); end
    endtask

    task automatic test_frame_err;
        int v0 = vcnt, f0 = fcnt;
        send_frame(8'h3C, 1'b0);
        wait_clk(3 * BIT);
        total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_held got=%b want=1", rx_busy); end
        total++; if (fcnt != f0 + 1) begin bad++; $display("FAIL ferr_cnt got=%0d want=1", fcnt - f0); end
        rx = 1'b1;
        wait_clk(40);
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_release got=%b want=0", rx_busy); end
        total++; if (fcnt != f0 + 1) begin bad++; $display("FAIL ferr_cnt_after got=%0d want=1", fcnt - f0); end
        total++; if (vcnt != v0) begin bad++; $display("FAIL ferr_valid_cnt got=%0d want=0", vcnt - v0); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL ferr_data got=%h want=a5", rx_data); end
    endtask

    task automatic test_back_to_back;
        int v0 = vcnt, f0 = fcnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clk(20);
        total++; if (vcnt != v0 + 2) begin bad++; $display("FAIL b2b_valid_cnt got=%0d want=2", vcnt - v0); end
        else begin
            total++; if (vlog[v0] !== 8'h00) begin bad++; $display("FAIL b2b_first got=%h want=00", vlog[v0]); end
            total++; if (vlog[v0+1] !== 8'hFF) begin bad++; $display("FAIL b2b_second got=%h want=ff", vlog[v0+1]); end
        end
        total++; if (fcnt != f0) begin bad++; $display("FAIL b2b_ferr_cnt got=%0d want=0", fcnt - f0); end
    endtask

    task automatic test_reset_mid;
        int v0 = vcnt, f0 = fcnt;
        logic [7:0] d = 8'hF3;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx = d[4];
        wait_clk(BIT / 2);
        rst_n = 1'b0;
        wait_clk(1);
        rst_n = 1'b1;
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h want=00", rx_data); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", rx_busy); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", rx_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_ferr got=%b want=0", frame_err); end
        wait_clk(BIT / 2 - 1);
        for (int i = 5; i < 8; i++) send_bit(d[i]);
        send_bit(1'b1);
        wait_clk(20);
        total++; if (vcnt != v0 || fcnt != f0) begin bad++; $display("FAIL rstmid_pulses got=%0d/%0d want=0/0", vcnt - v0, fcnt - f0); end
        send_frame(8'h5A, 1'b1);
        wait_clk(20);
        total++; if (vcnt != v0 + 1) begin bad++; $display("FAIL rstmid_next_cnt got=%0d want=1", vcnt - v0); end
        total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL rstmid_next_data got=%h want=5a", rx_data); end
    endtask

    task automatic test_loopback;
        int v0 = vcnt;
        logic [7:0] seq [3] = '{8'h01, 8'h80, 8'h7E};
        for (int i = 0; i < 3; i++) begin
            send_frame(seq[i], 1'b1);
            send_bit(1'b1);
        end
        wait_clk(20);
        total++; if (vcnt != v0 + 3) begin bad++; $display("FAIL loop_valid_cnt got=%0d want=3", vcnt - v0); end
        else for (int i = 0; i < 3; i++) begin
            total++; if (vlog[v0+i] !== seq[i]) begin bad++; $display("FAIL loop_byte%0d got=%h want=%h", i, vlog[v0+i], seq[i]); end
        end
    endtask

    task automatic test_pulses;
        total++; if (both != 0) begin bad++; $display("FAIL pulse_overlap got=%0d want=0", both); end
        total++; if (wide != 0) begin bad++; $display("FAIL pulse_width got=%0d want=0", wide); end
        total++; if (dchg != 0) begin bad++; $display("FAIL data_change_no_valid got=%0d want=0", dchg); end
    endtask

    initial begin
        test_reset();
        test_a5();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        test_pulses();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
